// File: rtl/sd_extract.sv
// rtl/sd_extract.sv - receive sideband extractor: header parse, sideband FIFO, payload forward
//
// Purpose:
//   Takes packets whose first word (sop) is a header, decodes the header into
//   exponent/symbol/slot/frame, queues those fields in a BLOCK_QTY-deep
//   sideband FIFO and forwards only the payload words through a one-register
//   valid/ready output stage. A packet arriving while the FIFO is full is
//   consumed and dropped; a header-only packet is counted as a runt.
//
// Ports:
//   clk, rst                 clock (posedge), asynchronous active-high reset
//   din_restart              synchronous flush of FSM, FIFO pointers and output stage
//   din_sop/eop/valid/data   input stream, din_ready back-pressure
//   dout_sop/eop/valid/data  payload stream, dout_ready back-pressure
//   sd_valid, sd_ready       sideband head available / pop
//   sd_exp/symbol/slot/frame head entry fields
//   sd_*_pre                 entry following the head (predictive read)
//   bloc_used/full/empty     sideband FIFO occupancy
//   overflow_cnt, runt_cnt   dropped-packet and runt-packet counters
module sd_extract #(
    parameter int DATA_WIDTH      = 32,
    parameter int BLOCK_QTY       = 5,
    parameter int BLOC_ADDR_WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       din_restart,
    input  logic                       din_sop,
    input  logic                       din_eop,
    input  logic                       din_valid,
    input  logic [DATA_WIDTH-1:0]      din_data,
    output logic                       din_ready,
    input  logic                       dout_ready,
    output logic                       dout_sop,
    output logic                       dout_eop,
    output logic                       dout_valid,
    output logic [DATA_WIDTH-1:0]      dout_data,
    input  logic                       sd_ready,
    output logic                       sd_valid,
    output logic [5:0]                 sd_exp,
    output logic [3:0]                 sd_symbol,
    output logic [7:0]                 sd_slot,
    output logic [9:0]                 sd_frame,
    output logic [5:0]                 sd_exp_pre,
    output logic [3:0]                 sd_symbol_pre,
    output logic [7:0]                 sd_slot_pre,
    output logic [9:0]                 sd_frame_pre,
    output logic [BLOC_ADDR_WIDTH-1:0] bloc_used,
    output logic                       bloc_full,
    output logic                       bloc_empty,
    output logic [31:0]                overflow_cnt,
    output logic [31:0]                runt_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        PAY,
        DROP
    } state_t;

    localparam logic [BLOC_ADDR_WIDTH-1:0] QTY  = BLOC_ADDR_WIDTH'(BLOCK_QTY);
    localparam logic [BLOC_ADDR_WIDTH-1:0] LAST = BLOC_ADDR_WIDTH'(BLOCK_QTY - 1);

    state_t                     state;
    logic                       first;
    logic [27:0]                hdr_stage;
    logic [27:0]                fifo_mem [BLOCK_QTY];
    logic [BLOC_ADDR_WIDTH-1:0] wr_ptr;
    logic [BLOC_ADDR_WIDTH-1:0] rd_ptr;
    logic [BLOC_ADDR_WIDTH-1:0] rd_pre;
    logic [BLOC_ADDR_WIDTH-1:0] wr_next;
    logic [BLOC_ADDR_WIDTH-1:0] rd_next;

    logic stage_free;
    logic din_hs;
    logic load;
    logic push;
    logic pop;

    assign stage_free = !dout_valid || dout_ready;
    assign din_ready  = (state == PAY) ? stage_free : 1'b1;
    assign din_hs     = din_valid && din_ready;
    assign load       = din_hs && (state == PAY);
    // The sideband entry is committed only once payload is known to exist,
    // so a header followed by nothing never leaves a dangling entry.
    assign push       = load && first;
    assign pop        = sd_ready && !bloc_empty;

    assign wr_next = (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
    assign rd_next = (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
    assign rd_pre  = rd_next;

    assign bloc_full  = (bloc_used == QTY);
    assign bloc_empty = (bloc_used == '0);
    assign sd_valid   = !bloc_empty;

    assign {sd_frame, sd_slot, sd_symbol, sd_exp}                 = fifo_mem[rd_ptr];
    assign {sd_frame_pre, sd_slot_pre, sd_symbol_pre, sd_exp_pre} = fifo_mem[rd_pre];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            first        <= 1'b0;
            hdr_stage    <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            bloc_used    <= '0;
            overflow_cnt <= '0;
            runt_cnt     <= '0;
            dout_valid   <= 1'b0;
            dout_sop     <= 1'b0;
            dout_eop     <= 1'b0;
            dout_data    <= '0;
            for (int i = 0; i < BLOCK_QTY; i++) begin
                fifo_mem[i] <= '0;
            end
        end else if (din_restart) begin
            // Flush wins over any handshake this cycle; counters and the
            // stored entries are left alone.
            state      <= IDLE;
            first      <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            bloc_used  <= '0;
            dout_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Non-sop words in IDLE are strays and simply consumed.
                    if (din_hs && din_sop) begin
                        if (din_eop) begin
                            runt_cnt <= runt_cnt + 32'd1;
                        end else if (bloc_full) begin
                            state <= DROP;
                        end else begin
                            state     <= PAY;
                            hdr_stage <= din_data[27:0];
                            first     <= 1'b1;
                        end
                    end
                end
                PAY: begin
                    if (din_hs) begin
                        first <= 1'b0;
                        if (din_eop) begin
                            state <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (din_hs && din_eop) begin
                        overflow_cnt <= overflow_cnt + 32'd1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (load) begin
                dout_valid <= 1'b1;
                dout_data  <= din_data;
                dout_sop   <= first;
                dout_eop   <= din_eop;
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end

            if (push) begin
                fifo_mem[wr_ptr] <= hdr_stage;
                wr_ptr           <= wr_next;
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            if (push && !pop) begin
                bloc_used <= bloc_used + 1'b1;
            end else if (pop && !push) begin
                bloc_used <= bloc_used - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sd_extract.sv
// tb/tb_sd_extract.sv - self-checking bench for sd_extract
module tb_sd_extract;

    localparam int QTY = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din_restart = 1'b0;
    logic        din_sop = 1'b0;
    logic        din_eop = 1'b0;
    logic        din_valid = 1'b0;
    logic [31:0] din_data = '0;
    logic        din_ready;
    logic        dout_ready = 1'b1;
    logic        dout_sop;
    logic        dout_eop;
    logic        dout_valid;
    logic [31:0] dout_data;
    logic        sd_ready = 1'b0;
    logic        sd_valid;
    logic [5:0]  sd_exp;
    logic [3:0]  sd_symbol;
    logic [7:0]  sd_slot;
    logic [9:0]  sd_frame;
    logic [5:0]  sd_exp_pre;
    logic [3:0]  sd_symbol_pre;
    logic [7:0]  sd_slot_pre;
    logic [9:0]  sd_frame_pre;
    logic [2:0]  bloc_used;
    logic        bloc_full;
    logic        bloc_empty;
    logic [31:0] overflow_cnt;
    logic [31:0] runt_cnt;

    sd_extract #(.DATA_WIDTH(32), .BLOCK_QTY(QTY), .BLOC_ADDR_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .din_restart(din_restart),
        .din_sop(din_sop), .din_eop(din_eop), .din_valid(din_valid),
        .din_data(din_data), .din_ready(din_ready),
        .dout_ready(dout_ready), .dout_sop(dout_sop), .dout_eop(dout_eop),
        .dout_valid(dout_valid), .dout_data(dout_data),
        .sd_ready(sd_ready), .sd_valid(sd_valid),
        .sd_exp(sd_exp), .sd_symbol(sd_symbol), .sd_slot(sd_slot), .sd_frame(sd_frame),
        .sd_exp_pre(sd_exp_pre), .sd_symbol_pre(sd_symbol_pre),
        .sd_slot_pre(sd_slot_pre), .sd_frame_pre(sd_frame_pre),
        .bloc_used(bloc_used), .bloc_full(bloc_full), .bloc_empty(bloc_empty),
        .overflow_cnt(overflow_cnt), .runt_cnt(runt_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [33:0] exp_q[$];   // {sop, eop, data} of every payload word expected on dout
    logic [27:0] sb_q[$];    // {frame, slot, symbol, exp} of every expected sideband entry
    int          ovf_exp = 0;
    int          runt_exp = 0;
    logic        bp_mode = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Downstream scoreboard: every accepted dout word must be the next expected one.
    always @(negedge clk) begin
        if (!rst && dout_valid && dout_ready) begin
            chk("dout_unexpected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                chk("dout_word", 64'({dout_sop, dout_eop, dout_data}), 64'(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic chk_sd();
        chk("sd_valid", 64'(sd_valid), 64'(sb_q.size() != 0));
        chk("bloc_used", 64'(bloc_used), 64'(sb_q.size()));
        chk("bloc_full", 64'(bloc_full), 64'(sb_q.size() == QTY));
        if (sb_q.size() != 0)
            chk("sd_head", 64'({sd_frame, sd_slot, sd_symbol, sd_exp}), 64'(sb_q[0]));
        if (sb_q.size() > 1)
            chk("sd_pre", 64'({sd_frame_pre, sd_slot_pre, sd_symbol_pre, sd_exp_pre}), 64'(sb_q[1]));
    endtask

    task automatic pop_sd();
        chk_sd();
        sd_ready = 1'b1;
        @(posedge clk); #1;
        sd_ready = 1'b0;
        if (sb_q.size() != 0) void'(sb_q.pop_front());
    endtask

    // Inputs change 1 time unit after posedge; din_ready is sampled at negedge.
    task automatic send_word(input logic sop, input logic eop, input logic [31:0] d, input logic in_pay);
        logic ok;
        din_sop = sop; din_eop = eop; din_data = d; din_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (bp_mode) dout_ready = ~dout_ready;
            @(negedge clk);
            if (in_pay) chk("din_ready", 64'(din_ready), 64'(!dout_valid || dout_ready));
            ok = din_ready;
            @(posedge clk); #1;
        end
        if (!ok) chk("din_timeout", 64'(0), 64'(1));
        din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    endtask

    task automatic send_packet(input logic [27:0] f, input int n, input logic pop_first);
        logic        accept;
        logic [31:0] d;
        if (n == 0) begin
            send_word(1'b1, 1'b1, {4'($urandom()), f}, 1'b0);
            runt_exp++;
        end else begin
            accept = (sb_q.size() < QTY);
            send_word(1'b1, 1'b0, {4'($urandom()), f}, 1'b0);
            for (int i = 0; i < n; i++) begin
                d = $urandom();
                if (accept) exp_q.push_back({i == 0, i == n - 1, d});
                if (i == 0 && pop_first) begin
                    chk_sd();
                    sd_ready = 1'b1;
                end
                send_word(1'b0, i == n - 1, d, accept);
                if (i == 0 && pop_first) begin
                    sd_ready = 1'b0;
                    if (sb_q.size() != 0) void'(sb_q.pop_front());
                end
                if (i == 0 && accept) sb_q.push_back(f);
                if (accept) begin
                    chk("dout_latency", 64'({dout_valid, dout_sop, dout_data}), 64'({1'b1, i == 0, d}));
                end
            end
            if (!accept) ovf_exp++;
        end
        chk("overflow_cnt", 64'(overflow_cnt), 64'(ovf_exp));
        chk("runt_cnt", 64'(runt_cnt), 64'(runt_exp));
        chk_sd();
    endtask

    function automatic logic [27:0] rand_hdr();
        return 28'($urandom());
    endfunction

    task automatic drain_dout();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("dout_drained", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        logic [31:0] d1;
        logic [31:0] d2;
        logic [27:0] f;

        // Reset state
        @(posedge clk); #1;
        chk("rst_empty", 64'({bloc_empty, bloc_full, sd_valid, dout_valid}), 64'(4'b1000));
        chk("rst_dout", 64'({dout_sop, dout_eop, dout_data}), 64'(0));
        chk("rst_sd", 64'({sd_frame, sd_slot, sd_symbol, sd_exp, sd_frame_pre, sd_slot_pre, sd_symbol_pre, sd_exp_pre}), 64'(0));
        chk("rst_cnt", 64'({overflow_cnt, runt_cnt}), 64'(0));
        chk("rst_used", 64'(bloc_used), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Single packet with the reference header
        send_packet({10'h0A4, 8'h0C, 4'h3, 6'h15}, 3, 1'b0);
        chk("single_fields", 64'({sd_exp, sd_symbol, sd_slot, sd_frame}), 64'({6'h15, 4'h3, 8'h0C, 10'h0A4}));
        drain_dout();
        pop_sd();

        // Runt then stray
        send_packet(rand_hdr(), 0, 1'b0);
        send_word(1'b0, 1'b0, $urandom(), 1'b0);
        chk("runt_used", 64'({runt_cnt, bloc_used}), 64'({32'd1, 3'd0}));

        // Fill and overflow
        for (int k = 0; k < QTY + 1; k++) begin
            send_packet(rand_hdr(), 2, 1'b0);
            if (k == QTY - 1) chk("fill_full", 64'({bloc_used, bloc_full}), 64'({3'd5, 1'b1}));
        end
        chk("ovf_one", 64'({overflow_cnt, bloc_used}), 64'({32'd1, 3'd5}));
        drain_dout();
        for (int k = 0; k < QTY; k++) pop_sd();

        // Backpressure on a 10-word payload
        bp_mode = 1'b1;
        send_packet(rand_hdr(), 10, 1'b0);
        bp_mode = 1'b0;
        dout_ready = 1'b1;
        drain_dout();
        pop_sd();

        // Restart mid-PAY
        f = rand_hdr();
        send_word(1'b1, 1'b0, {4'h0, f}, 1'b0);
        d1 = $urandom(); d2 = $urandom();
        exp_q.push_back({2'b10, d1});
        send_word(1'b0, 1'b0, d1, 1'b1);
        exp_q.push_back({2'b00, d2});
        send_word(1'b0, 1'b0, d2, 1'b1);
        din_restart = 1'b1;
        @(posedge clk); #1;
        din_restart = 1'b0;
        sb_q.delete();
        chk("restart_state", 64'({bloc_empty, dout_valid, sd_valid, bloc_used}), 64'({3'b100, 3'd0}));
        chk("restart_cnt", 64'({overflow_cnt, runt_cnt}), 64'({32'(ovf_exp), 32'(runt_exp)}));
        send_word(1'b0, 1'b1, $urandom(), 1'b0);   // rest of the flushed packet: ignored in IDLE
        drain_dout();

        // Wrap and predictive read: frames 1..7, one pop per packet after the third
        for (int k = 1; k <= 7; k++) begin
            send_packet({10'(k), 18'($urandom())}, 1, 1'b0);
            if (k > 3) pop_sd();
        end
        chk("wrap_pre", 64'({sd_frame, sd_frame_pre}), 64'({10'd5, 10'd6}));
        while (sb_q.size() != 0) pop_sd();
        drain_dout();

        // Push and pop in the same cycle at occupancy 2
        send_packet(rand_hdr(), 1, 1'b0);
        send_packet(rand_hdr(), 1, 1'b0);
        send_packet(rand_hdr(), 2, 1'b1);
        chk("simul_used", 64'(bloc_used), 64'(2));
        drain_dout();
        while (sb_q.size() != 0) pop_sd();

        // Random traffic
        for (int k = 0; k < 30; k++) begin
            send_packet(rand_hdr(), $urandom_range(0, 4), 1'b0);
            if (sb_q.size() != 0 && $urandom_range(0, 2) == 0) pop_sd();
        end
        drain_dout();
        while (sb_q.size() != 0) pop_sd();
        chk_sd();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sd_extract.md
Name: sd_extract

Overview:
- Receive-side counterpart of the transmit sideband store-and-forward path.
- Parses the header word at the start of each incoming packet into sideband fields: exponent, symbol, slot and frame.
- Queues those fields in a BLOCK_QTY-deep sideband FIFO and strips the header from the stream.
- Forwards the payload through a registered valid/ready stage, so downstream sees payload on one interface and per-packet sideband on a separate pop interface.

Parameters:
- DATA_WIDTH, 32: stream data width; minimum 28. Header fields occupy bits [27:0].
- BLOCK_QTY, 5: sideband FIFO depth in packets; minimum 2.
- BLOC_ADDR_WIDTH, 3: FIFO pointer/used-count width. Must represent BLOCK_QTY.

Ports:
- clk  input  1  clock, posedge active
- rst  input  1  reset, asynchronous, active high
- din_restart  input  1  synchronous flush of FSM, FIFO and output stage
- din_sop  input  1  input start of packet; marks the header word
- din_eop  input  1  input end of packet
- din_valid  input  1  input data valid
- din_data  input  DATA_WIDTH  input data
- din_ready  output  1  input ready
- dout_ready  input  1  payload output ready
- dout_sop  output  1  first payload word
- dout_eop  output  1  last payload word
- dout_valid  output  1  payload valid
- dout_data  output  DATA_WIDTH  payload data
- sd_ready  input  1  sideband pop
- sd_valid  output  1  sideband entry available (FIFO not empty)
- sd_exp  output  6  head entry exponent
- sd_symbol  output  4  head entry symbol
- sd_slot  output  8  head entry slot
- sd_frame  output  10  head entry frame
- sd_exp_pre, sd_symbol_pre, sd_slot_pre, sd_frame_pre  output  6/4/8/10  entry after head, predictive
- bloc_used  output  BLOC_ADDR_WIDTH  FIFO occupancy, 0..BLOCK_QTY
- bloc_full  output  1  bloc_used == BLOCK_QTY
- bloc_empty  output  1  bloc_used == 0
- overflow_cnt  output  32  packets dropped because the FIFO was full
- runt_cnt  output  32  packets discarded because they carried no payload

Behaviour:
- Reset: FSM=IDLE; pointers, bloc_used, counters = 0; FIFO entries = 0; dout_valid = 0. Outputs: bloc_empty=1, bloc_full=0, sd_valid=0, all dout_*/sd_* fields = 0.
- Header decode:
  - exp = data[5:0]
  - symbol = data[9:6]
  - slot = data[17:10]
  - frame = data[27:18]
  - data[DATA_WIDTH-1:28] is ignored.
- Output stage is one register.
  - stage_free = !dout_valid | dout_ready.
  - A word loads on a din handshake in PAY.
  - dout_valid clears when dout_ready is high and nothing loads.
  - Payload latency: 1 cycle.
- din_ready:
  - 1 in IDLE and DROP.
  - stage_free in PAY.
- FSM states and transitions:
  - IDLE: a handshake with din_sop=1 is the header.
    - FIFO not full and din_eop=0: go to PAY and latch the header into the staging register; set first=1.
    - FIFO full and din_eop=0: go to DROP.
    - din_eop=1 (header-only packet): stay in IDLE, push nothing, runt_cnt+1. This applies whether or not the FIFO is full.
    - A handshake with din_sop=0 is discarded silently.
  - PAY: each handshake loads the output stage.
    - dout_sop=first on the loaded word, then first clears.
    - dout_eop=din_eop.
    - The sideband entry is pushed on the first payload handshake, so a sideband entry never exists without payload.
    - On din_eop: go to IDLE.
    - din_sop=1 while in PAY is treated as data (no resync).
  - DROP: all words are consumed and nothing is output. On din_eop: overflow_cnt+1, go to IDLE.
- FIFO:
  - Write pointer advances on push; read pointer advances on sd_ready & sd_valid.
  - Both wrap from BLOCK_QTY-1 to 0.
  - Push and pop in the same cycle: bloc_used unchanged. A pop while empty is ignored.
  - sd_* reads entry[rd_ptr]; sd_*_pre reads entry[rd_ptr==BLOCK_QTY-1 ? 0 : rd_ptr+1]. Both are combinational from the registers.
  - Fullness is checked at the header. It cannot be violated at the push, because pops only reduce occupancy.
- din_restart, sampled on clk:
  - FSM to IDLE; pointers and bloc_used to 0; dout_valid to 0.
  - Counters hold. Restart takes priority over any concurrent handshake.
- rst asserted mid-packet: everything returns to reset state immediately. The remaining words of that packet are discarded as non-sop in IDLE.
- Counters are 32-bit and wrap modulo 2^32.

Test Plan:
- Single packet:
  - Stimulus: header 0x0A4_0C_3_15 (frame=0x0A4, slot=0x0C, symbol=3, exp=0x15), then 3 payload words, dout_ready=1.
  - Required: dout shows the 3 words one cycle late, sop on word 1 and eop on word 3. After the first payload word, sd_valid=1 with sd_exp=0x15, sd_symbol=3, sd_slot=0x0C, sd_frame=0x0A4; bloc_used=1.
- Fill and overflow:
  - Stimulus: 6 packets with sd_ready=0 and BLOCK_QTY=5.
  - Required: bloc_used=5 and bloc_full=1 after packet 5. Packet 6 produces no dout; overflow_cnt=1 and bloc_used stays 5.
- Wrap and predictive read:
  - Stimulus: push 7 packets with frames 1..7, popping one entry per packet after the third.
  - Required: pointers wrap. Each sd_frame_pre equals the next pushed frame, and entry 4's pre wraps to the entry at address 0.
- Backpressure:
  - Stimulus: dout_ready toggled 1/0 during a 10-word payload.
  - Required: no word lost or duplicated. din_ready follows stage_free, and data order is preserved.
- Runt and stray:
  - Stimulus: header with eop in the same word, then a non-sop word while in IDLE.
  - Required: runt_cnt=1, bloc_used=0, no dout activity.
- Simultaneous events:
  - Stimulus: a push in the same cycle as sd_ready with bloc_used=2.
  - Required: bloc_used remains 2.
  - Stimulus: din_restart mid-PAY.
  - Required: next cycle FSM=IDLE, bloc_empty=1, dout_valid=0, counters unchanged.
